// File: rtl/mask_filter_pkg.sv
// Shared types and constants for the 3x3 foreground-mask majority filter.
package mask_filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPadCol,
        StPadRow
    } state_e;

    localparam logic [7:0] FG_ON  = 8'hFF;
    localparam logic [7:0] FG_OFF = 8'h00;

    localparam int unsigned DEF_WIDTH  = 320;
    localparam int unsigned DEF_HEIGHT = 240;
    localparam int unsigned DEF_THRESH = 5;

    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + 4'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mask_line_buffer.sv
// Two chained 1-bit delay lines of one padded line each; tap1 is row r-1, tap2 is row r-2.
module mask_line_buffer
    import mask_filter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_WIDTH + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic adv_i,
    input  logic bit_i,
    output logic tap1_o,
    output logic tap2_o
);

    logic [DEPTH-1:0] line1_q;
    logic [DEPTH-1:0] line2_q;

    assign tap1_o = line1_q[DEPTH-1];
    assign tap2_o = line2_q[DEPTH-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line1_q <= '0;
            line2_q <= '0;
        end else if (adv_i) begin
            line1_q <= {line1_q[DEPTH-2:0], bit_i};
            line2_q <= {line2_q[DEPTH-2:0], line1_q[DEPTH-1]};
        end
    end

endmodule

// File: rtl/mask_majority_filter.sv
// Streaming 3x3 binary majority filter over a padded (HEIGHT+1)x(WIDTH+1) scan.
module mask_majority_filter
    import mask_filter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned THRESH = DEF_THRESH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       sop_in,
    input  logic       eop_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       sop_out,
    output logic       eop_out,
    output logic       frame_err
);

    localparam int unsigned RW = $clog2(HEIGHT + 1);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e        state_q, state_d;
    logic [RW-1:0] r_q, r_d, pos_r;
    logic [CW-1:0] c_q, c_d, pos_c;
    logic [2:0]    col1_q, col2_q, new_col, prev1, prev2;
    logic          advance, accept, process, cur, err_set, emit;
    logic          lb_tap1, lb_tap2;
    logic [3:0]    count;

    mask_line_buffer #(
        .DEPTH (WIDTH + 1)
    ) u_line_buffer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adv_i  (process),
        .bit_i  (cur),
        .tap1_o (lb_tap1),
        .tap2_o (lb_tap2)
    );

    always_comb begin
        advance   = !valid_out | ready_in;
        ready_out = !rst_i && advance && (state_q == StIdle || state_q == StRun);
        accept    = valid_in & ready_out;
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        pos_r     = r_q;
        pos_c     = c_q;
        process   = 1'b0;
        cur       = 1'b0;
        err_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept && sop_in) begin
                    process = 1'b1;
                    cur     = |data_in;
                    pos_r   = '0;
                    pos_c   = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    process = 1'b1;
                    cur     = |data_in;
                    if (sop_in) begin
                        pos_r   = '0;
                        pos_c   = '0;
                        err_set = 1'b1;
                    end
                end
            end
            StPadCol, StPadRow: begin
                process = advance;
            end
        endcase

        if (accept && process && eop_in &&
            !(pos_r == RW'(HEIGHT - 1) && pos_c == CW'(WIDTH - 1))) begin
            err_set = 1'b1;
        end

        // One scan position per processed cycle: real pixels, then the pad column, then pad row.
        if (process) begin
            if (pos_r == RW'(HEIGHT)) begin
                if (pos_c == CW'(WIDTH)) begin
                    state_d = StIdle;
                    r_d     = '0;
                    c_d     = '0;
                end else begin
                    state_d = StPadRow;
                    r_d     = pos_r;
                    c_d     = pos_c + 1'b1;
                end
            end else if (pos_c == CW'(WIDTH)) begin
                r_d     = pos_r + 1'b1;
                c_d     = '0;
                state_d = (pos_r == RW'(HEIGHT - 1)) ? StPadRow : StRun;
            end else begin
                r_d     = pos_r;
                c_d     = pos_c + 1'b1;
                state_d = (pos_c == CW'(WIDTH - 1)) ? StPadCol : StRun;
            end
        end

        new_col = {(pos_r >= RW'(2)) ? lb_tap2 : 1'b0,
                   (pos_r >= RW'(1)) ? lb_tap1 : 1'b0,
                   cur};
        prev1   = (pos_c >= CW'(1)) ? col1_q : 3'b000;
        prev2   = (pos_c >= CW'(2)) ? col2_q : 3'b000;
        count   = popcount9({prev2, prev1, new_col});
        emit    = process && (pos_r != '0) && (pos_c != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            r_q       <= '0;
            c_q       <= '0;
            col1_q    <= '0;
            col2_q    <= '0;
            data_out  <= FG_OFF;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (err_set) begin
                frame_err <= 1'b1;
            end
            if (advance) begin
                state_q   <= state_d;
                r_q       <= r_d;
                c_q       <= c_d;
                if (process) begin
                    col1_q <= new_col;
                    col2_q <= prev1;
                end
                valid_out <= emit;
                data_out  <= (emit && count >= 4'(THRESH)) ? FG_ON : FG_OFF;
                sop_out   <= emit && pos_r == RW'(1) && pos_c == CW'(1);
                eop_out   <= emit && pos_r == RW'(HEIGHT) && pos_c == CW'(WIDTH);
            end
        end
    end

endmodule

// File: tb/tb_mask_majority_filter.sv
// Directed bench for mask_majority_filter on an 8x6 frame.
module tb_mask_majority_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int T = 5;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in, ready_out, sop_in, eop_in;
    logic [7:0] data_out;
    logic       valid_out, ready_in, sop_out, eop_out, frame_err;

    beat_t      bq[$];
    logic [7:0] img[N];
    logic [7:0] cap[$];
    bit         got_eop, got_sop;
    int         eop_idx;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mask_majority_filter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .THRESH (T)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count foreground over the in-frame 3x3 neighbourhood.
    function automatic logic [7:0] model(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                    if (img[(r + dr) * W + c + dc] != 8'h00) n++;
                end
            end
        end
        return (n >= T) ? 8'hFF : 8'h00;
    endfunction

    task automatic load_frame(input int count);
        for (int i = 0; i < count; i++) begin
            bq.push_back('{d: img[i], sop: (i == 0), eop: (i == N - 1)});
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       img[i] = 8'h00;
                1:       img[i] = 8'hFF;
                default: img[i] = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
            endcase
        end
    endtask

    task automatic run(input bit rnd, input int stop_after);
        int         accepted;
        bit         in_x, hold;
        logic [7:0] hd;
        logic       hs, he;
        accepted = 0;
        hold     = 1'b0;
        got_eop  = 1'b0;
        got_sop  = 1'b0;
        eop_idx  = -1;
        cap.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (got_eop && bq.size() == 0) break;
            if (stop_after >= 0 && accepted == stop_after) break;
            valid_in = (bq.size() != 0) && (!rnd || $urandom_range(1, 0) == 1);
            data_in  = valid_in ? bq[0].d : 8'h00;
            sop_in   = valid_in ? bq[0].sop : 1'b0;
            eop_in   = valid_in ? bq[0].eop : 1'b0;
            ready_in = !rnd || $urandom_range(1, 0) == 1;
            @(negedge clk);
            in_x = valid_in && ready_out;
            if (hold) begin
                check("hold_data", data_out, hd);
                check("hold_flags", {valid_out, sop_out, eop_out}, {1'b1, hs, he});
            end
            hold = valid_out && !ready_in;
            hd   = data_out;
            hs   = sop_out;
            he   = eop_out;
            if (valid_out && ready_in) begin
                if (sop_out) begin
                    cap.delete();
                    got_sop = 1'b1;
                end
                cap.push_back(data_out);
                if (eop_out) begin
                    got_eop = 1'b1;
                    eop_idx = cap.size();
                end
            end
            @(posedge clk);
            #1;
            if (in_x) begin
                void'(bq.pop_front());
                accepted++;
            end
        end
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        data_in  = 8'h00;
        ready_in = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_sop"}, 32'(got_sop), 32'd1);
        check({tag, "_eop"}, 32'(got_eop), 32'd1);
        check({tag, "_count"}, cap.size(), N);
        check({tag, "_eop_pos"}, eop_idx, N);
        if (cap.size() == N) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("%s_px%0d", tag, i), cap[i], model(i / W, i % W));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data_out, 8'h00);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_sop"}, sop_out, 1'b0);
        check({tag, "_eop"}, eop_out, 1'b0);
        check({tag, "_err"}, frame_err, 1'b0);
        check({tag, "_ready"}, ready_out, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        data_in  = 8'h00;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All background.
        fill(0);
        load_frame(N);
        run(1'b0, -1);
        check_frame("zero");
        check("zero_first", (cap.size() > 0) ? cap[0] : 8'hxx, 8'h00);
        check("zero_err", frame_err, 1'b0);

        // All foreground: corners see 4, edges 6, interior 9.
        fill(1);
        load_frame(N);
        run(1'b0, -1);
        check_frame("ones");
        if (cap.size() == N) begin
            check("ones_corner_tl", cap[0], 8'h00);
            check("ones_corner_tr", cap[W - 1], 8'h00);
            check("ones_corner_bl", cap[N - W], 8'h00);
            check("ones_corner_br", cap[N - 1], 8'h00);
            check("ones_edge_top", cap[1], 8'hFF);
            check("ones_edge_left", cap[W], 8'hFF);
            check("ones_interior", cap[3 * W + 3], 8'hFF);
        end

        // Isolated pixel is removed.
        fill(0);
        img[3 * W + 3] = 8'h01;
        load_frame(N);
        run(1'b0, -1);
        check_frame("single");
        if (cap.size() == N) check("single_centre", cap[3 * W + 3], 8'h00);

        // 3x3 block: its corners only see 4 foreground neighbours.
        fill(0);
        for (int r = 2; r <= 4; r++) begin
            for (int c = 2; c <= 4; c++) img[r * W + c] = 8'h80;
        end
        load_frame(N);
        run(1'b0, -1);
        check_frame("block");
        if (cap.size() == N) begin
            check("block_centre", cap[3 * W + 3], 8'hFF);
            check("block_edge", cap[2 * W + 3], 8'hFF);
            check("block_corner", cap[2 * W + 2], 8'h00);
            check("block_outside", cap[1 * W + 3], 8'h00);
        end

        // Random frame under random valid/ready.
        fill(2);
        load_frame(N);
        run(1'b1, -1);
        check_frame("random");
        check("random_err", frame_err, 1'b0);

        // sop_in arrives as pixel 20 of a frame; the new frame must win.
        fill(2);
        load_frame(20);
        fill(2);
        load_frame(N);
        run(1'b0, -1);
        check_frame("sop_restart");
        check("sop_restart_err", frame_err, 1'b1);

        // Reset after 30 pixels, then a clean frame.
        fill(2);
        load_frame(N);
        run(1'b0, 30);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bq.delete();
        fill(2);
        load_frame(N);
        run(1'b0, -1);
        check_frame("post_reset");
        check("post_reset_err", frame_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
